// File: rtl/mmio_button_ctrl_pkg.sv
// Shared MMIO constants for the button peripheral.
package mmio_button_ctrl_pkg;

  localparam logic [31:0] BTN_ADDR              = 32'h1000_0008;
  localparam int unsigned BTN_FLAG_LSB          = 0;
  localparam int unsigned BTN_LEVEL_LSB         = 8;
  localparam int unsigned BTN_OVR_LSB           = 16;
  localparam int unsigned BTN_DEBOUNCE_DEFAULT  = 1_000_000;

endpackage

// File: rtl/mmio_button_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser plus stable-level debouncer for one button.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous raw button input
//   level      : debounced level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any sample agreeing with the current level restarts the count,
      // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/mmio_button_ctrl.sv
// mmio_button_ctrl: debounced buttons with sticky W1C press flags and overrun bits.
//   clk, reset    : clock, synchronous active-high reset
//   btn_raw       : raw asynchronous buttons
//   btn_read_en   : decoder read strobe; read_data is 0 when low
//   btn_write_en  : decoder write strobe; write_data bits are W1C
//   read_data     : {overrun @16, level @8, flags @0}
//   btn_level     : debounced levels
module mmio_button_ctrl
  import mmio_button_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               btn_read_en,
  input  logic               btn_write_en,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] stable_d;
  logic [NUM_BTN-1:0] flag;
  logic [NUM_BTN-1:0] overrun;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] flag_clr;
  logic [NUM_BTN-1:0] ovr_clr;
  logic [31:0]        image;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(stable[i])
    );
  end

  assign rise     = stable & ~stable_d;
  assign flag_clr = btn_write_en ? write_data[BTN_FLAG_LSB +: NUM_BTN] : '0;
  assign ovr_clr  = btn_write_en ? write_data[BTN_OVR_LSB +: NUM_BTN]  : '0;
  assign unused_wdata = ^write_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
      flag     <= '0;
      overrun  <= '0;
    end else begin
      stable_d <= stable;
      // Sets dominate same-cycle clears so no press or overrun is lost.
      flag     <= rise | (flag & ~flag_clr);
      overrun  <= (rise & flag) | (overrun & ~ovr_clr);
    end
  end

  always_comb begin
    image = '0;
    image[BTN_FLAG_LSB  +: NUM_BTN] = flag;
    image[BTN_LEVEL_LSB +: NUM_BTN] = stable;
    image[BTN_OVR_LSB   +: NUM_BTN] = overrun;
  end

  assign read_data = (btn_read_en && !reset) ? image : '0;
  assign btn_level = reset ? '0 : stable;

endmodule

// File: tb/tb_mmio_button_ctrl.sv
module tb_mmio_button_ctrl;

  localparam int unsigned NB = 5;
  localparam int unsigned DC = 4;

  typedef bit [NB-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic          btn_read_en = 1'b0;
  logic          btn_write_en = 1'b0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic [NB-1:0] btn_level;

  always #5 clk = ~clk;

  mmio_button_ctrl #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_read_en(btn_read_en),
    .btn_write_en(btn_write_en),
    .write_data(write_data),
    .read_data(read_data),
    .btn_level(btn_level)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DC synchronised
  // samples (raw delayed by two clocks) all disagree with the accepted level.
  vec_t m_stable, m_stable_d, m_flag, m_ovr;
  vec_t hist[$];   // hist[0] = raw at previous edge, hist[1] = two edges ago, ...

  task automatic model_reset();
    m_stable = '0; m_stable_d = '0; m_flag = '0; m_ovr = '0;
    hist.delete();
    for (int unsigned j = 0; j <= DC; j++) hist.push_back('0);
  endtask

  task automatic model_edge();
    vec_t nxt;
    bit   all_diff, r, f;
    if (reset) begin
      model_reset();
    end else begin
      nxt = m_stable;
      for (int unsigned i = 0; i < NB; i++) begin
        all_diff = 1'b1;
        for (int unsigned j = 1; j <= DC; j++)
          if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
      for (int unsigned i = 0; i < NB; i++) begin
        r = m_stable[i] && !m_stable_d[i];
        f = m_flag[i];
        if (r && f) m_ovr[i] = 1'b1;
        else if (r) m_flag[i] = 1'b1;
        else if (btn_write_en && write_data[i]) m_flag[i] = 1'b0;
        if (btn_write_en && write_data[16+i] && !(r && f)) m_ovr[i] = 1'b0;
      end
      m_stable_d = m_stable;
      m_stable   = nxt;
      hist.push_front(vec_t'(btn_raw));
      void'(hist.pop_back());
    end
  endtask

  function automatic logic [31:0] exp_read();
    logic [31:0] img;
    img = '0;
    if (btn_read_en && !reset) begin
      img[NB-1:0]  = m_flag;
      img[8 +: NB] = m_stable;
      img[16 +: NB] = m_ovr;
    end
    return img;
  endfunction

  // Apply inputs, check outputs against the model, then advance one clock.
  task automatic cyc(input logic [NB-1:0] raw, input logic rd, input logic wr,
                     input logic [31:0] wd, input logic rst);
    logic [31:0] exp_lvl;
    btn_raw = raw; btn_read_en = rd; btn_write_en = wr; write_data = wd; reset = rst;
    #1;
    exp_lvl = '0;
    if (!reset) exp_lvl[NB-1:0] = m_stable;
    check_val("read_data", read_data, exp_read());
    check_val("btn_level", {27'b0, btn_level}, exp_lvl);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [NB-1:0] raw, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cyc(raw, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [NB-1:0] raw, input logic [31:0] d);
    cyc(raw, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd_check(input logic [NB-1:0] raw, input string tag, input logic [31:0] exp);
    cyc(raw, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val(tag, read_data, exp);
  endtask

  // Hold raw and count edges until flag bit b reads back set (bounded).
  task automatic press_wait(input logic [NB-1:0] raw, input int unsigned b, output int unsigned lat);
    lat = 99;
    for (int unsigned n = 1; n <= 12; n++) begin
      cyc(raw, 1'b1, 1'b0, 32'h0, 1'b0);
      if (read_data[b] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int unsigned lat;
    bit          seen, hit;
    int unsigned hold[NB];
    logic [NB-1:0] rv;

    model_reset();
    for (int unsigned k = 0; k < 3; k++) cyc('0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle('0, 3);

    // Clean press on button 0
    press_wait(5'h01, 0, lat);
    check_val("press_lat", lat, 7);
    check_val("clean_read", read_data, 32'h0000_0101);
    idle(5'h01, 1);
    check_val("clean_noread", read_data, 32'h0);
    idle('0, 8);
    wr('0, 32'h1);
    rd_check('0, "clean_clr", 32'h0);

    // Bounce rejection on button 1
    seen = 1'b0;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned m = 0; m < 2; m++) begin
        idle((k % 2 == 0) ? 5'h02 : 5'h00, 1);
        seen |= btn_level[1];
      end
    for (int unsigned k = 0; k < 10; k++) begin
      idle('0, 1);
      seen |= btn_level[1];
    end
    check_val("bounce_level", {31'b0, seen}, 32'h0);
    rd_check('0, "bounce_read", 32'h0);

    // W1C and set-wins-over-clear on button 2
    idle(5'h04, 10);
    idle('0, 8);
    rd_check('0, "w1c_before", 32'h0000_0004);
    wr('0, 32'h4);
    rd_check('0, "w1c_after", 32'h0);
    hit = 1'b0;
    for (int unsigned n = 0; n < 15; n++) begin
      if (m_stable[2] && !m_stable_d[2]) begin
        wr(5'h04, 32'h4);
        hit = 1'b1;
        break;
      end
      idle(5'h04, 1);
    end
    check_val("setwins_hit", {31'b0, hit}, 32'h1);
    rd_check(5'h04, "setwins", 32'h0000_0404);
    idle('0, 8);
    wr('0, 32'h4);

    // Overrun on button 3
    idle(5'h08, 10);
    idle('0, 8);
    idle(5'h08, 10);
    idle('0, 8);
    rd_check('0, "overrun", 32'h0008_0008);
    wr('0, 32'h0008_0008);
    rd_check('0, "overrun_clr", 32'h0);

    // Selective clear, buttons 0 and 4
    idle(5'h11, 10);
    idle('0, 8);
    rd_check('0, "sel_set", 32'h0000_0011);
    wr('0, 32'h1);
    rd_check('0, "sel_clr0", 32'h0000_0010);
    wr('0, 32'hFFE0_FFE0);
    rd_check('0, "sel_ignored", 32'h0000_0010);
    wr('0, 32'h0);
    rd_check('0, "sel_zero_wr", 32'h0000_0010);
    wr('0, 32'h10);

    // Reset while button 0 is held
    press_wait(5'h01, 0, lat);
    check_val("rst_pre_lat", lat, 7);
    for (int unsigned k = 0; k < 3; k++) begin
      cyc(5'h01, 1'b1, 1'b0, 32'h0, 1'b1);
      check_val("rst_read", read_data, 32'h0);
    end
    press_wait(5'h01, 0, lat);
    check_val("rst_post_lat", lat, 7);
    check_val("rst_post_read", read_data, 32'h0000_0101);
    idle(5'h01, 6);
    rd_check(5'h01, "rst_one_flag", 32'h0000_0101);
    idle('0, 8);
    wr('0, 32'h0001_0001);

    // Randomised traffic against the model
    rv = '0;
    for (int unsigned i = 0; i < NB; i++) hold[i] = $urandom_range(1, 10);
    for (int unsigned c = 0; c < 1500; c++) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          rv[i] = ~rv[i];
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      cyc(rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          $urandom, ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
